// File: rtl/pc_sequencer_if.sv
// rtl/pc_sequencer_if.sv - bus, compare-flag and fetch signals of the program-counter sequencer
//
// Purpose: groups the system-bus write port, the compare-unit flags and the
// instruction-register fetch handshake of pc_sequencer into one bundle.
// Names carry the sequencer's point of view (i_ = into the sequencer).
//
// Signals:
//   i_wr_en       bus write strobe, one cycle per write
//   i_device      target device ID
//   i_address     port code
//   i_data        write data
//   i_cmp_larger  compare flag, sampled on the write cycle
//   i_cmp_smaller compare flag, sampled on the write cycle
//   i_cmp_equal   compare flag, sampled on the write cycle
//   i_ir_ready    fetch accepted by instruction register
//   o_ir_fetch_en fetch request
//   o_ir_pointer  instruction address
//   o_jump_taken  one-cycle pulse, pointer was loaded from target
//   o_halted      sequencer is in STOP
//   o_waiting     sequencer is in WAIT
//
// Modports: slave = the sequencer, master = the bus / compare / IR side.
interface pc_sequencer_if #(
  parameter int DATA_WIDTH = 8
);
  logic                  i_wr_en;
  logic [DATA_WIDTH-1:0] i_device;
  logic [DATA_WIDTH-1:0] i_address;
  logic [DATA_WIDTH-1:0] i_data;
  logic                  i_cmp_larger;
  logic                  i_cmp_smaller;
  logic                  i_cmp_equal;
  logic                  i_ir_ready;
  logic                  o_ir_fetch_en;
  logic [DATA_WIDTH-1:0] o_ir_pointer;
  logic                  o_jump_taken;
  logic                  o_halted;
  logic                  o_waiting;

  modport slave (
    input  i_wr_en, i_device, i_address, i_data,
    input  i_cmp_larger, i_cmp_smaller, i_cmp_equal, i_ir_ready,
    output o_ir_fetch_en, o_ir_pointer, o_jump_taken, o_halted, o_waiting
  );

  modport master (
    output i_wr_en, i_device, i_address, i_data,
    output i_cmp_larger, i_cmp_smaller, i_cmp_equal, i_ir_ready,
    input  o_ir_fetch_en, o_ir_pointer, o_jump_taken, o_halted, o_waiting
  );
endinterface

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program-counter sequencer: jumps, timed waits, stop and fetch gating
//
// Purpose: decodes bus writes addressed to the controller device and owns the
// instruction pointer. Handles conditional/unconditional jumps against a
// programmable target, timed waits, stop, and gates instruction fetch through
// the IR ready handshake.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-high reset
//   bus  pc_sequencer_if.slave: write port, compare flags, fetch handshake,
//        pointer and status outputs
module pc_sequencer #(
  parameter int                    DATA_WIDTH        = 8,
  parameter logic [DATA_WIDTH-1:0] DEVICE_CONTROLLER = 'h01,
  parameter logic [DATA_WIDTH-1:0] PORT_JUMP_LARGER  = 'd0,
  parameter logic [DATA_WIDTH-1:0] PORT_JUMP_SMALLER = 'd1,
  parameter logic [DATA_WIDTH-1:0] PORT_JUMP_EQUAL   = 'd2,
  parameter logic [DATA_WIDTH-1:0] PORT_JUMP_UNEQUAL = 'd3,
  parameter logic [DATA_WIDTH-1:0] PORT_JUMP_DIRECT  = 'd4,
  parameter logic [DATA_WIDTH-1:0] PORT_ADDR         = 'd5,
  parameter logic [DATA_WIDTH-1:0] PORT_WAIT         = 'd6,
  parameter logic [DATA_WIDTH-1:0] PORT_STOP         = 'd7
) (
  input  logic         clk,
  input  logic         rst,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {
    ST_RST  = 2'd0,
    ST_RUN  = 2'd1,
    ST_WAIT = 2'd2,
    ST_STOP = 2'd3
  } state_t;

  state_t                r_state;
  logic [DATA_WIDTH-1:0] r_pointer;
  logic [DATA_WIDTH-1:0] r_target;
  logic [DATA_WIDTH-1:0] r_wait_cnt;
  logic                  r_jump_taken;

  state_t                w_nxt_state;
  logic [DATA_WIDTH-1:0] w_nxt_pointer;
  logic [DATA_WIDTH-1:0] w_nxt_target;
  logic [DATA_WIDTH-1:0] w_nxt_wait_cnt;
  logic                  w_nxt_jump_taken;

  logic w_accept;
  logic w_wr_addr;
  logic w_wr_wait;
  logic w_wr_stop;
  logic w_wr_direct;
  logic w_jump_hit;

  // A write only exists for this block when strobed and addressed to it.
  assign w_accept    = bus.i_wr_en && (bus.i_device == DEVICE_CONTROLLER);
  assign w_wr_addr   = w_accept && (bus.i_address == PORT_ADDR);
  assign w_wr_wait   = w_accept && (bus.i_address == PORT_WAIT);
  assign w_wr_stop   = w_accept && (bus.i_address == PORT_STOP);
  assign w_wr_direct = w_accept && (bus.i_address == PORT_JUMP_DIRECT);

  // Taken-jump decode; unknown port codes fall through as "no jump".
  always_comb begin
    w_jump_hit = 1'b0;
    if (w_accept) begin
      case (bus.i_address)
        PORT_JUMP_LARGER:  w_jump_hit = bus.i_cmp_larger;
        PORT_JUMP_SMALLER: w_jump_hit = bus.i_cmp_smaller;
        PORT_JUMP_EQUAL:   w_jump_hit = bus.i_cmp_equal;
        PORT_JUMP_UNEQUAL: w_jump_hit = !bus.i_cmp_equal;
        PORT_JUMP_DIRECT:  w_jump_hit = 1'b1;
        default:           w_jump_hit = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RST;
      r_pointer    <= '0;
      r_target     <= '0;
      r_wait_cnt   <= '0;
      r_jump_taken <= 1'b0;
    end else begin
      r_state      <= w_nxt_state;
      r_pointer    <= w_nxt_pointer;
      r_target     <= w_nxt_target;
      r_wait_cnt   <= w_nxt_wait_cnt;
      r_jump_taken <= w_nxt_jump_taken;
    end
  end

  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_pointer    = r_pointer;
    w_nxt_target     = r_target;
    w_nxt_wait_cnt   = r_wait_cnt;
    w_nxt_jump_taken = 1'b0;

    // The target is writable everywhere except STOP; jumps in this same
    // cycle still use the old value because they read r_target.
    if (w_wr_addr && (r_state != ST_STOP)) begin
      w_nxt_target = bus.i_data;
    end

    case (r_state)
      ST_RST: begin
        if (w_wr_direct) begin
          w_nxt_pointer    = r_target;
          w_nxt_jump_taken = 1'b1;
          w_nxt_state      = ST_RUN;
        end
      end

      ST_RUN: begin
        // Priority: STOP > taken jump > WAIT (non-zero) > fetch increment.
        if (w_wr_stop) begin
          w_nxt_state = ST_STOP;
        end else if (w_jump_hit) begin
          w_nxt_pointer    = r_target;
          w_nxt_jump_taken = 1'b1;
        end else if (w_wr_wait && (bus.i_data != '0)) begin
          w_nxt_wait_cnt = bus.i_data;
          w_nxt_state    = ST_WAIT;
        end else if (bus.i_ir_ready) begin
          w_nxt_pointer = r_pointer + DATA_WIDTH'(1);
        end
      end

      ST_WAIT: begin
        // wait_cnt holds N on the first WAIT cycle, so leaving when it
        // reads 1 gives exactly N cycles of WAIT.
        if (w_wr_stop) begin
          w_nxt_state = ST_STOP;
        end else begin
          w_nxt_wait_cnt = r_wait_cnt - DATA_WIDTH'(1);
          if (r_wait_cnt == DATA_WIDTH'(1)) begin
            w_nxt_state = ST_RUN;
          end
        end
      end

      ST_STOP: begin
        w_nxt_state = ST_STOP;
      end

      default: begin
        w_nxt_state = ST_RST;
      end
    endcase
  end

  // Status outputs come from registers only, never from inputs.
  assign bus.o_ir_fetch_en = (r_state == ST_RUN);
  assign bus.o_halted      = (r_state == ST_STOP);
  assign bus.o_waiting     = (r_state == ST_WAIT);
  assign bus.o_ir_pointer  = r_pointer;
  assign bus.o_jump_taken  = r_jump_taken;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - directed self-checking bench for pc_sequencer
module tb_pc_sequencer;

  localparam int DW = 8;
  localparam logic [7:0] P_LARGER  = 8'd0;
  localparam logic [7:0] P_SMALLER = 8'd1;
  localparam logic [7:0] P_EQUAL   = 8'd2;
  localparam logic [7:0] P_UNEQUAL = 8'd3;
  localparam logic [7:0] P_DIRECT  = 8'd4;
  localparam logic [7:0] P_ADDR    = 8'd5;
  localparam logic [7:0] P_WAIT    = 8'd6;
  localparam logic [7:0] P_STOP    = 8'd7;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  pc_sequencer_if #(.DATA_WIDTH(DW)) bus ();

  pc_sequencer #(.DATA_WIDTH(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] dev, input logic [7:0] port, input logic [7:0] data);
    bus.i_wr_en     = 1'b1;
    bus.i_device    = dev;
    bus.i_address   = port;
    bus.i_data      = data;
    tick();
    bus.i_wr_en     = 1'b0;
    bus.i_device    = 8'h00;
    bus.i_address   = 8'h00;
    bus.i_data      = 8'h00;
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    bus.i_wr_en       = 1'b0;
    bus.i_device      = 8'h00;
    bus.i_address     = 8'h00;
    bus.i_data        = 8'h00;
    bus.i_cmp_larger  = 1'b0;
    bus.i_cmp_smaller = 1'b0;
    bus.i_cmp_equal   = 1'b0;
    bus.i_ir_ready    = 1'b0;
    tick();
    tick();

    chk("rst_ptr",   bus.o_ir_pointer, 32'h00);
    chk("rst_fetch", bus.o_ir_fetch_en, 32'h0);
    chk("rst_jt",    bus.o_jump_taken, 32'h0);
    chk("rst_halt",  bus.o_halted, 32'h0);
    chk("rst_wait",  bus.o_waiting, 32'h0);
    rst = 1'b0;

    // ADDR then DIRECT out of RST
    wr(8'h01, P_ADDR, 8'h10);
    chk("rst_addr_fetch", bus.o_ir_fetch_en, 32'h0);
    wr(8'h01, P_DIRECT, 8'h00);
    chk("direct_ptr",   bus.o_ir_pointer, 32'h10);
    chk("direct_jt",    bus.o_jump_taken, 32'h1);
    chk("direct_fetch", bus.o_ir_fetch_en, 32'h1);
    tick();
    chk("jt_one_cycle", bus.o_jump_taken, 32'h0);

    // Three fetch handshakes
    bus.i_ir_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.i_ir_ready = 1'b0;
    chk("inc3_ptr", bus.o_ir_pointer, 32'h13);
    tick();
    chk("no_ready_hold", bus.o_ir_pointer, 32'h13);

    // Conditional jumps
    wr(8'h01, P_ADDR, 8'h40);
    bus.i_cmp_equal = 1'b0;
    wr(8'h01, P_EQUAL, 8'h00);
    chk("eq_nt_ptr", bus.o_ir_pointer, 32'h13);
    chk("eq_nt_jt",  bus.o_jump_taken, 32'h0);
    bus.i_cmp_smaller = 1'b1;
    wr(8'h01, P_LARGER, 8'h00);
    chk("lg_nt_ptr", bus.o_ir_pointer, 32'h13);
    bus.i_cmp_smaller = 1'b0;
    wr(8'h01, P_UNEQUAL, 8'h00);
    chk("ueq_ptr", bus.o_ir_pointer, 32'h40);
    chk("ueq_jt",  bus.o_jump_taken, 32'h1);

    // Wrap from FF and jump-over-increment priority
    wr(8'h01, P_ADDR, 8'hFF);
    wr(8'h01, P_DIRECT, 8'h00);
    chk("ptr_ff", bus.o_ir_pointer, 32'hFF);
    wr(8'h01, P_ADDR, 8'h20);
    bus.i_ir_ready = 1'b1;
    tick();
    chk("wrap_ptr", bus.o_ir_pointer, 32'h00);
    wr(8'h01, P_DIRECT, 8'h00);
    chk("jump_beats_inc", bus.o_ir_pointer, 32'h20);

    // WAIT 3 with ready held high: WAIT also beats the increment
    wr(8'h01, P_WAIT, 8'h03);
    chk("w1_wait",  bus.o_waiting, 32'h1);
    chk("w1_fetch", bus.o_ir_fetch_en, 32'h0);
    chk("w1_ptr",   bus.o_ir_pointer, 32'h20);
    tick();
    chk("w2_wait", bus.o_waiting, 32'h1);
    tick();
    chk("w3_wait", bus.o_waiting, 32'h1);
    chk("w3_ptr",  bus.o_ir_pointer, 32'h20);
    tick();
    chk("w4_wait",  bus.o_waiting, 32'h0);
    chk("w4_fetch", bus.o_ir_fetch_en, 32'h1);
    chk("w4_ptr",   bus.o_ir_pointer, 32'h20);
    tick();
    bus.i_ir_ready = 1'b0;
    chk("after_wait_inc", bus.o_ir_pointer, 32'h21);

    wr(8'h01, P_WAIT, 8'h00);
    chk("wait0_wait",  bus.o_waiting, 32'h0);
    chk("wait0_fetch", bus.o_ir_fetch_en, 32'h1);

    // Foreign device writes ignored
    wr(8'h02, P_DIRECT, 8'h00);
    chk("dev2_ptr", bus.o_ir_pointer, 32'h21);
    chk("dev2_jt",  bus.o_jump_taken, 32'h0);
    wr(8'h02, P_STOP, 8'h00);
    chk("dev2_stop", bus.o_halted, 32'h0);

    // STOP and its sticky freeze
    wr(8'h01, P_STOP, 8'h00);
    chk("stop_halt",  bus.o_halted, 32'h1);
    chk("stop_fetch", bus.o_ir_fetch_en, 32'h0);
    bus.i_ir_ready = 1'b1;
    wr(8'h01, P_DIRECT, 8'h00);
    wr(8'h01, P_ADDR, 8'h77);
    wr(8'h01, P_DIRECT, 8'h00);
    bus.i_ir_ready = 1'b0;
    chk("stop_ptr",  bus.o_ir_pointer, 32'h21);
    chk("stop_jt",   bus.o_jump_taken, 32'h0);
    chk("stop_halt2", bus.o_halted, 32'h1);

    // Reset mid-WAIT, asynchronously
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wr(8'h01, P_ADDR, 8'h30);
    wr(8'h01, P_DIRECT, 8'h00);
    chk("rerun_ptr", bus.o_ir_pointer, 32'h30);
    wr(8'h01, P_WAIT, 8'h05);
    tick();
    chk("pre_rst_wait", bus.o_waiting, 32'h1);
    #3;
    rst = 1'b1;
    #1;
    chk("async_wait",  bus.o_waiting, 32'h0);
    chk("async_ptr",   bus.o_ir_pointer, 32'h00);
    chk("async_fetch", bus.o_ir_fetch_en, 32'h0);
    chk("async_halt",  bus.o_halted, 32'h0);
    tick();
    rst = 1'b0;

    // LARGER in RST ignored; DIRECT then shows target was cleared
    bus.i_cmp_larger = 1'b1;
    wr(8'h01, P_LARGER, 8'h00);
    bus.i_cmp_larger = 1'b0;
    chk("rst_lg_fetch", bus.o_ir_fetch_en, 32'h0);
    chk("rst_lg_jt",    bus.o_jump_taken, 32'h0);
    wr(8'h01, P_DIRECT, 8'h00);
    chk("rst_tgt_ptr", bus.o_ir_pointer, 32'h00);
    chk("rst_tgt_jt",  bus.o_jump_taken, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
